// File: rtl/sign_restore_pkg.sv
// Shared multiplier-datapath constants: default product width, latency and
// the sign-restore FSM state encoding.
package sign_restore_pkg;

  localparam int SR_WIDTH         = 16;
  localparam int SIGN_RESTORE_LAT = SR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

endpackage

// File: rtl/sign_restore_serial_negate_bit.sv
// One-bit serial two's complement cell: copy bits through the first 1,
// invert every later bit when negation is requested.
module serial_negate_bit (
  input  logic b,
  input  logic seenOne,
  input  logic neg,
  output logic o,
  output logic seenOneNext
);

  assign o           = (neg & seenOne) ? ~b : b;
  assign seenOneNext = seenOne | b;

endmodule

// File: rtl/sign_restore.sv
// Re-applies the product sign to an unsigned magnitude, one bit per clock LSB-first.
// Optional SIGN_RESTORE_FAST_EN: non-negative or zero requests skip the serial pass.
module sign_restore
  import sign_restore_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mag,
  input  logic             sign_a,
  input  logic             sign_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: start is sampled only in IDLE; busy is high from the capture
  // edge until done drops; done is a single-cycle pulse with result/ovf valid.
  stateT            state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    counter;
  logic             seenOne;
  logic             neg;
  logic             ovfPend;

  logic capNeg;
  logic capOvf;
  logic bitOut;
  logic seenNext;

  assign capNeg = sign_a ^ sign_b;
  // -2^(WIDTH-1) is the one negative value whose magnitude has the MSB set.
  assign capOvf = capNeg ? (mag > MIN_NEG) : mag[WIDTH-1];

  serial_negate_bit uNegBit (
    .b          (sr[0]),
    .seenOne    (seenOne),
    .neg        (neg),
    .o          (bitOut),
    .seenOneNext(seenNext)
  );

`ifdef SIGN_RESTORE_FAST_EN
  logic fastPath;
  assign fastPath = ~capNeg | (mag == '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sr      <= '0;
      acc     <= '0;
      counter <= '0;
      seenOne <= 1'b0;
      neg     <= 1'b0;
      ovfPend <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= mag;
            neg     <= capNeg;
            ovfPend <= capOvf;
            counter <= '0;
            seenOne <= 1'b0;
            busy    <= 1'b1;
`ifdef SIGN_RESTORE_FAST_EN
            if (fastPath) begin
              result <= mag;
              ovf    <= capOvf;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= SHIFT;
            end
`else
            state   <= SHIFT;
`endif
          end
        end
        SHIFT: begin
          sr      <= sr >> 1;
          acc     <= {bitOut, acc[WIDTH-1:1]};
          seenOne <= seenNext;
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            result <= {bitOut, acc[WIDTH-1:1]};
            ovf    <= ovfPend;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_restore.sv
// Directed bench for sign_restore: hand-computed vectors, latency, reset abort
// and busy-protocol checks.
module tb_sign_restore;
  import sign_restore_pkg::*;

  localparam int W = SR_WIDTH;

  typedef struct packed {
    logic [W-1:0] m;
    logic         sa;
    logic         sb;
    logic [W-1:0] r;
    logic         o;
  } vecT;

  localparam int NV = 10;
  localparam vecT VECS [NV] = '{
    '{16'h0003, 1'b1, 1'b0, 16'hFFFD, 1'b0},
    '{16'h1234, 1'b1, 1'b1, 16'h1234, 1'b0},
    '{16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0},
    '{16'h8000, 1'b1, 1'b0, 16'h8000, 1'b0},
    '{16'h8001, 1'b0, 1'b1, 16'h7FFF, 1'b1},
    '{16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1},
    '{16'h00FF, 1'b1, 1'b0, 16'hFF01, 1'b0},
    '{16'h7FFF, 1'b0, 1'b0, 16'h7FFF, 1'b0},
    '{16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b1},
    '{16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0}
  };

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] mag = '0;
  logic         sign_a = 1'b0;
  logic         sign_b = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;

  int vecCount  = 0;
  int missCount = 0;

  logic [W-1:0] exp_q[$];
  logic         ovf_q[$];

  sign_restore #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mag   (mag),
    .sign_a(sign_a),
    .sign_b(sign_b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int expCycles(input vecT v);
`ifdef SIGN_RESTORE_FAST_EN
    if (!(v.sa ^ v.sb) || v.m == '0) return 0;
`endif
    return SIGN_RESTORE_LAT - 1;
  endfunction

  // Drive a request at a negedge and return at the negedge after capture.
  task automatic launch(input vecT v);
    start  = 1'b1;
    mag    = v.m;
    sign_a = v.sa;
    sign_b = v.sb;
    exp_q.push_back(v.r);
    ovf_q.push_back(v.o);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count edges from capture to done; optionally pulse a stray start mid-shift.
  task automatic finishVec(input vecT v, input string tag, input int glitchAt, input bit hold);
    int           cycles;
    logic [W-1:0] er;
    logic         eo;
    cycles = 0;
    if (!hold) start = 1'b0;
    while (!done && cycles < 40) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (!hold && !done) begin
        start = (cycles == glitchAt);
        if (cycles == glitchAt) begin
          mag    = 16'h5555;
          sign_a = 1'b0;
          sign_b = 1'b0;
        end
      end
    end
    start = hold;
    checkVal({tag, " latency"}, W'(cycles), W'(expCycles(v)));
    er = exp_q.pop_front();
    eo = ovf_q.pop_front();
    checkVal({tag, " result"}, result, er);
    checkVal({tag, " ovf"}, W'(ovf), W'(eo));
    checkVal({tag, " busy@done"}, W'(busy), W'(1));
    @(posedge clk);
    @(negedge clk);
    checkVal({tag, " done drop"}, W'(done), W'(0));
    checkVal({tag, " busy drop"}, W'(busy), W'(0));
    if (!hold) begin
      repeat (3) @(negedge clk);
      checkVal({tag, " result hold"}, result, er);
    end
  endtask

  initial begin
    int doneSeen;
    repeat (3) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checkVal("reset busy", W'(busy), W'(0));
    checkVal("reset done", W'(done), W'(0));
    checkVal("reset result", result, '0);
    checkVal("reset ovf", W'(ovf), W'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      launch(VECS[i]);
      finishVec(VECS[i], $sformatf("vec%0d", i), -1, 1'b0);
    end

    // Reset during SHIFT aborts without a done pulse.
    launch('{16'h00FF, 1'b1, 1'b0, 16'hFF01, 1'b0});
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_back());
    void'(ovf_q.pop_back());
    checkVal("abort busy", W'(busy), W'(0));
    checkVal("abort result", result, '0);
    checkVal("abort ovf", W'(ovf), W'(0));
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkVal("abort no done", W'(doneSeen), W'(0));

    // Stray start during SHIFT is ignored.
    launch('{16'h0003, 1'b1, 1'b0, 16'hFFFD, 1'b0});
    finishVec('{16'h0003, 1'b1, 1'b0, 16'hFFFD, 1'b0}, "ignore", 4, 1'b0);

    // start held high: one IDLE edge between done and the next capture.
    launch('{16'h0005, 1'b0, 1'b1, 16'hFFFB, 1'b0});
    finishVec('{16'h0005, 1'b0, 1'b1, 16'hFFFB, 1'b0}, "b2b first", -1, 1'b1);
    mag    = 16'h0042;
    sign_a = 1'b1;
    sign_b = 1'b1;
    exp_q.push_back(16'h0042);
    ovf_q.push_back(1'b0);
    @(posedge clk);
    @(negedge clk);
    checkVal("b2b capture busy", W'(busy), W'(1));
    finishVec('{16'h0042, 1'b1, 1'b1, 16'h0042, 1'b0}, "b2b second", -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
